// File: rtl/udma_lin_tx_responder.sv
// Single-channel uDMA linear TX responder: serves peripheral data requests by
// fetching words from L2 and returning right-aligned items over valid/ready.
module udma_lin_tx_responder #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [1:0]                datasize_i,
  output logic [31:0]               data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      mem_rvalid_i,
  output logic                      end_evt_o
);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, MEM_REQ, MEM_WAIT, DATA} state_t;

  state_t                    state_reg;
  logic [L2_AWIDTH_NOAL-1:0] curr_addr_reg;
  logic [TRANS_SIZE-1:0]     bytes_left_reg;
  logic [L2_AWIDTH_NOAL-1:0] start_reg;
  logic [TRANS_SIZE-1:0]     size_reg;
  logic                      cont_reg;
  logic [L2_AWIDTH_NOAL-1:0] sh_start_reg;
  logic [TRANS_SIZE-1:0]     sh_size_reg;
  logic                      sh_cont_reg;
  logic                      pending_reg;
  logic                      en_reg;
  logic [1:0]                ds_reg;
  logic [31:0]               data_reg;
  logic                      valid_reg;
  logic                      gnt_reg;
  logic                      mem_req_reg;
  logic                      end_evt_reg;

  logic [2:0]            step_b;
  logic [TRANS_SIZE-1:0] left_next;
  logic                  handshake;
  logic                  done;
  logic                  shadow_hit;
  logic [31:0]           rdata_shift;
  logic [31:0]           rdata_masked;

  always_comb begin
    case (ds_reg)
      2'd0:    step_b = 3'd1;
      2'd1:    step_b = 3'd2;
      default: step_b = 3'd4;
    endcase
  end

  assign left_next  = (bytes_left_reg > TRANS_SIZE'(step_b)) ?
                      bytes_left_reg - TRANS_SIZE'(step_b) : '0;
  assign handshake  = (state_reg == DATA) && ready_i;
  // Completion: either an empty transfer waiting for requests, or the last handshake.
  assign done       = ((state_reg == WAIT_REQ) && (bytes_left_reg == '0)) ||
                      (handshake && (left_next == '0));
  assign shadow_hit = cfg_en_i && en_reg;

  assign rdata_shift = mem_rdata_i >> {curr_addr_reg[1:0], 3'b000};
  always_comb begin
    case (ds_reg)
      2'd0:    rdata_masked = {24'd0, rdata_shift[7:0]};
      2'd1:    rdata_masked = {16'd0, rdata_shift[15:0]};
      default: rdata_masked = rdata_shift;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      curr_addr_reg  <= '0;
      bytes_left_reg <= '0;
      start_reg      <= '0;
      size_reg       <= '0;
      cont_reg       <= 1'b0;
      sh_start_reg   <= '0;
      sh_size_reg    <= '0;
      sh_cont_reg    <= 1'b0;
      pending_reg    <= 1'b0;
      en_reg         <= 1'b0;
      ds_reg         <= 2'd0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      gnt_reg        <= 1'b0;
      mem_req_reg    <= 1'b0;
      end_evt_reg    <= 1'b0;
    end else if (cfg_clr_i) begin
      state_reg      <= IDLE;
      en_reg         <= 1'b0;
      pending_reg    <= 1'b0;
      bytes_left_reg <= '0;
      valid_reg      <= 1'b0;
      mem_req_reg    <= 1'b0;
      gnt_reg        <= 1'b0;
      end_evt_reg    <= 1'b0;
    end else begin
      gnt_reg     <= 1'b0;
      end_evt_reg <= 1'b0;

      if (shadow_hit && !done) begin
        sh_start_reg <= cfg_startaddr_i;
        sh_size_reg  <= cfg_size_i;
        sh_cont_reg  <= cfg_continuous_i;
        pending_reg  <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (cfg_en_i) begin
            curr_addr_reg  <= cfg_startaddr_i;
            bytes_left_reg <= cfg_size_i;
            start_reg      <= cfg_startaddr_i;
            size_reg       <= cfg_size_i;
            cont_reg       <= cfg_continuous_i;
            en_reg         <= 1'b1;
            state_reg      <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (bytes_left_reg != '0 && req_i) begin
            ds_reg      <= datasize_i;
            gnt_reg     <= 1'b1;
            mem_req_reg <= 1'b1;
            state_reg   <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_gnt_i) begin
            mem_req_reg <= 1'b0;
            state_reg   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_rvalid_i) begin
            data_reg  <= rdata_masked;
            valid_reg <= 1'b1;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (ready_i) begin
            valid_reg      <= 1'b0;
            curr_addr_reg  <= curr_addr_reg + L2_AWIDTH_NOAL'(step_b);
            bytes_left_reg <= left_next;
            state_reg      <= WAIT_REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Completion overrides the per-state updates above; an enable arriving in
      // the same cycle is treated as the newest queued transfer.
      if (done) begin
        end_evt_reg <= 1'b1;
        if (pending_reg || shadow_hit) begin
          curr_addr_reg  <= shadow_hit ? cfg_startaddr_i : sh_start_reg;
          bytes_left_reg <= shadow_hit ? cfg_size_i : sh_size_reg;
          start_reg      <= shadow_hit ? cfg_startaddr_i : sh_start_reg;
          size_reg       <= shadow_hit ? cfg_size_i : sh_size_reg;
          cont_reg       <= shadow_hit ? cfg_continuous_i : sh_cont_reg;
          pending_reg    <= 1'b0;
          state_reg      <= WAIT_REQ;
        end else if (cont_reg) begin
          curr_addr_reg  <= start_reg;
          bytes_left_reg <= size_reg;
          state_reg      <= WAIT_REQ;
        end else begin
          en_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      end
    end
  end

  assign cfg_en_o         = en_reg;
  assign cfg_pending_o    = pending_reg;
  assign cfg_curr_addr_o  = curr_addr_reg;
  assign cfg_bytes_left_o = bytes_left_reg;
  assign gnt_o            = gnt_reg;
  assign data_o           = data_reg;
  assign valid_o          = valid_reg;
  assign mem_req_o        = mem_req_reg;
  assign end_evt_o        = end_evt_reg;
  assign mem_addr_o       = {{(32-L2_AWIDTH_NOAL){1'b0}}, curr_addr_reg[L2_AWIDTH_NOAL-1:2], 2'b00};

endmodule
